// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared FSM state encoding and board clock default for the input-conditioning blocks
package button_debouncer_pkg;
  localparam int unsigned CLK_HZ = 12_000_000;
  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_IDLE_HIGH = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;
endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchroniser; ports clock, reset (sync, active-high), d (async in), q (synchronised out)
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw button and waits STABLE_COUNT stable cycles before moving clean_out; ports clock, reset (sync, active-high), noisy_in, clean_out, rise_pulse, fall_pulse
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_COUNT = 12000,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(STABLE_COUNT - 1);
  logic sync;
  logic [COUNT_WIDTH-1:0] count;
  state_t state;
  sync_2ff u_sync (
    .clock(clock),
    .reset(reset),
    .d    (noisy_in),
    .q    (sync)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE_LOW;
      count      <= '0;
      clean_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        ST_IDLE_LOW: begin
          count <= '0;
          if (sync) state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (!sync) begin
            state <= ST_IDLE_LOW;
            count <= '0;
          end else if (count == LAST) begin
            state      <= ST_IDLE_HIGH;
            count      <= '0;
            clean_out  <= 1'b1;
            rise_pulse <= 1'b1;
          end else count <= count + 1'b1;
        end
        ST_IDLE_HIGH: begin
          count <= '0;
          if (!sync) state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (sync) begin
            state <= ST_IDLE_HIGH;
            count <= '0;
          end else if (count == LAST) begin
            state      <= ST_IDLE_LOW;
            count      <= '0;
            clean_out  <= 1'b0;
            fall_pulse <= 1'b1;
          end else count <= count + 1'b1;
        end
        default: begin
          state <= ST_IDLE_LOW;
          count <= '0;
        end
      endcase
    end
  end
endmodule
